// File: rtl/sd_init_sequencer_if.sv
// sd_init_sequencer_if - command request / response channel between the init sequencer and the SD command engine
//
// master : the init sequencer (drives the command, consumes the response)
// slave  : the bit-level command/response engine
//   cmd_valid/cmd_ready        command handshake, transfer = valid & ready
//   cmd_index/arg/crc/resp_long command fields, held stable while cmd_valid is high
//   resp_valid/resp_timeout    1-cycle response or no-response pulse
//   resp_data                  [39:32] R1, [31:0] payload of R3/R7
interface sd_init_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic [6:0]  cmd_crc;
    logic        cmd_resp_long;
    logic        resp_valid;
    logic        resp_timeout;
    logic [39:0] resp_data;

    modport master (
        output cmd_valid, cmd_index, cmd_arg, cmd_crc, cmd_resp_long,
        input  cmd_ready, resp_valid, resp_timeout, resp_data
    );

    modport slave (
        input  cmd_valid, cmd_index, cmd_arg, cmd_crc, cmd_resp_long,
        output cmd_ready, resp_valid, resp_timeout, resp_data
    );
endinterface

// File: rtl/sd_init_sequencer.sv
// sd_init_sequencer - SD card SPI-mode power-up sequencer (CMD0, CMD8, CMD55+ACMD41 loop, optional CMD58)
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   start        1-cycle pulse, begins init from IDLE/DONE/ERROR, ignored while busy
//   cmd          sd_init_sequencer_if.master, command/response channel to the engine
//   busy         sequence in progress
//   init_done    sticky card-ready flag
//   init_error   sticky failure flag, err_code gives the cause
//   err_code     1 CMD0, 2 CMD8, 3 CMD55, 4 ACMD41, 5 CMD58, 6 timeout, 7 R1 framing
//   card_v2      card echoed the CMD8 check pattern
//   card_hc      high-capacity card
//   clk_fast     0 = 400 kHz SD clock divider, 1 = 25 MHz divider
//
// Build option: SD_INIT_OCR_READ_EN adds the CMD58 OCR read and takes card_hc from OCR[30];
// without it ACMD41 success goes straight to DONE and card_hc follows card_v2.
module sd_init_sequencer #(
    parameter int unsigned POWERUP_CYCLES    = 100000,
    parameter int unsigned CMD0_RETRIES      = 10,
    parameter int unsigned ACMD41_RETRIES    = 1000,
    parameter int unsigned ACMD41_GAP_CYCLES = 100000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    sd_init_sequencer_if.master        cmd,
    output logic                       busy,
    output logic                       init_done,
    output logic                       init_error,
    output logic [3:0]                 err_code,
    output logic                       card_v2,
    output logic                       card_hc,
    output logic                       clk_fast
);

    typedef enum logic [3:0] {
        IDLE, PWRUP, CMD0, CMD0_R, CMD8, CMD8_R, CMD55, CMD55_R,
        ACMD41, ACMD41_R, GAP, CMD58, CMD58_R, DONE, ERROR
    } state_t;

    state_t      state;
    logic [31:0] cyc;      // power-up and inter-ACMD41 delay counter
    logic [31:0] tries;    // failed attempts of the command currently being retried

    // Fields of the command owned by the current state; registered into the interface below.
    logic        is_cmd;
    logic [5:0]  c_index;
    logic [31:0] c_arg;
    logic [6:0]  c_crc;
    logic        c_long;
    state_t      c_resp_state;

    logic [7:0]  r1;
    assign r1 = cmd.resp_data[39:32];

    always_comb begin
        is_cmd       = 1'b1;
        c_index      = 6'd0;
        c_arg        = 32'h0;
        c_crc        = 7'h7F;
        c_long       = 1'b0;
        c_resp_state = IDLE;
        case (state)
            CMD0:   begin c_crc = 7'h4A; c_resp_state = CMD0_R; end
            CMD8:   begin
                c_index = 6'd8; c_arg = 32'h0000_01AA; c_crc = 7'h43;
                c_long = 1'b1; c_resp_state = CMD8_R;
            end
            CMD55:  begin c_index = 6'd55; c_resp_state = CMD55_R; end
            ACMD41: begin
                c_index = 6'd41; c_resp_state = ACMD41_R;
                c_arg   = card_v2 ? 32'h4000_0000 : 32'h0;   // HCS only offered to v2 cards
            end
            CMD58:  begin c_index = 6'd58; c_long = 1'b1; c_resp_state = CMD58_R; end
            default: is_cmd = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            cyc               <= 32'd0;
            tries             <= 32'd0;
            cmd.cmd_valid     <= 1'b0;
            cmd.cmd_index     <= 6'd0;
            cmd.cmd_arg       <= 32'h0;
            cmd.cmd_crc       <= 7'h0;
            cmd.cmd_resp_long <= 1'b0;
            busy              <= 1'b0;
            init_done         <= 1'b0;
            init_error        <= 1'b0;
            err_code          <= 4'd0;
            card_v2           <= 1'b0;
            card_hc           <= 1'b0;
            clk_fast          <= 1'b0;
        end else if (is_cmd) begin
            cmd.cmd_valid     <= 1'b1;
            cmd.cmd_index     <= c_index;
            cmd.cmd_arg       <= c_arg;
            cmd.cmd_crc       <= c_crc;
            cmd.cmd_resp_long <= c_long;
            if (cmd.cmd_valid && cmd.cmd_ready) begin
                cmd.cmd_valid <= 1'b0;
                state         <= c_resp_state;
            end
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (state == DONE) begin
                        init_done <= 1'b1;
                        clk_fast  <= 1'b1;
                        busy      <= 1'b0;
                    end
                    if (state == ERROR) begin
                        init_error <= 1'b1;
                        clk_fast   <= 1'b0;
                        busy       <= 1'b0;
                    end
                    if (start) begin
                        state      <= PWRUP;
                        cyc        <= 32'd0;
                        tries      <= 32'd0;
                        busy       <= 1'b1;
                        init_done  <= 1'b0;
                        init_error <= 1'b0;
                        err_code   <= 4'd0;
                        card_v2    <= 1'b0;
                        card_hc    <= 1'b0;
                        clk_fast   <= 1'b0;
                    end
                end
                PWRUP: begin
                    if (cyc == POWERUP_CYCLES - 1) begin
                        cyc   <= 32'd0;
                        state <= CMD0;
                    end else begin
                        cyc <= cyc + 32'd1;
                    end
                end
                GAP: begin
                    if (cyc == ACMD41_GAP_CYCLES - 1) begin
                        cyc   <= 32'd0;
                        state <= CMD55;
                    end else begin
                        cyc <= cyc + 32'd1;
                    end
                end
                default: begin
                    // *_R states; timeout has priority over a simultaneous response
                    if (cmd.resp_timeout) begin
                        if (state == CMD0_R) begin
                            if (tries == CMD0_RETRIES - 1) begin
                                err_code <= 4'd1; state <= ERROR;
                            end else begin
                                tries <= tries + 32'd1; state <= CMD0;
                            end
                        end else begin
                            err_code <= 4'd6; state <= ERROR;
                        end
                    end else if (cmd.resp_valid) begin
                        if (r1[7]) begin
                            err_code <= 4'd7; state <= ERROR;
                        end else begin
                            case (state)
                                CMD0_R: begin
                                    if (r1 == 8'h01) begin
                                        tries <= 32'd0; state <= CMD8;
                                    end else if (tries == CMD0_RETRIES - 1) begin
                                        err_code <= 4'd1; state <= ERROR;
                                    end else begin
                                        tries <= tries + 32'd1; state <= CMD0;
                                    end
                                end
                                CMD8_R: begin
                                    if (r1 == 8'h01 && cmd.resp_data[11:0] == 12'h1AA) begin
                                        card_v2 <= 1'b1; state <= CMD55;
                                    end else if (r1[2]) begin
                                        // illegal command: v1 card that does not know CMD8
                                        card_v2 <= 1'b0; state <= CMD55;
                                    end else begin
                                        err_code <= 4'd2; state <= ERROR;
                                    end
                                end
                                CMD55_R: begin
                                    if (r1 == 8'h00 || r1 == 8'h01) state <= ACMD41;
                                    else begin err_code <= 4'd3; state <= ERROR; end
                                end
                                ACMD41_R: begin
                                    if (r1 == 8'h00) begin
`ifdef SD_INIT_OCR_READ_EN
                                        state <= CMD58;
`else
                                        card_hc <= card_v2;
                                        state   <= DONE;
`endif
                                    end else if (r1 == 8'h01 && tries != ACMD41_RETRIES - 1) begin
                                        tries <= tries + 32'd1;
                                        cyc   <= 32'd0;
                                        state <= GAP;
                                    end else begin
                                        err_code <= 4'd4; state <= ERROR;
                                    end
                                end
                                CMD58_R: begin
                                    if (r1 == 8'h00) begin
                                        card_hc <= cmd.resp_data[30]; state <= DONE;
                                    end else begin
                                        err_code <= 4'd5; state <= ERROR;
                                    end
                                end
                                default: state <= IDLE;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule
